// File: rtl/analog_probe_sampler_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// analog_probe_sampler_pkg : shared types and constants for the probe sampler
// Revision: 1.0
// ----------------------------------------------------------------------------
package analog_probe_sampler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_V  = 3'd1,
    ST_WAIT_V = 3'd2,
    ST_REQ_I  = 3'd3,
    ST_WAIT_I = 3'd4,
    ST_ACCUM  = 3'd5,
    ST_DONE   = 3'd6
  } sampler_state_e;

  localparam int SAMPLER_MAX_SAMPLES = 256;

  // Value the probe model returns for an unresolved node.
  localparam real PROBE_INVALID_VALUE = 0.123456;

endpackage

`default_nettype wire

// File: rtl/analog_probe_sampler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// analog_probe_sampler : triggers the analog probe, captures voltage/current
//                        samples and reduces them to mean/min/max statistics
// Revision: 1.0
// ----------------------------------------------------------------------------
module analog_probe_sampler
  import analog_probe_sampler_pkg::*;
#(
  parameter int NUM_SAMPLES   = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic probe_voltage_toggle,
  output logic probe_current_toggle,
  input  real  voltage_in,
  input  real  current_in,
  output logic result_valid,
  input  logic result_ready,
  output real  v_mean,
  output real  v_min,
  output real  v_max,
  output real  i_mean
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int N_W   = $clog2(SAMPLER_MAX_SAMPLES) + 1;

  localparam logic [CNT_W-1:0] c_settle_load = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_W-1:0]   c_num_samples = N_W'(NUM_SAMPLES);
  localparam real              c_div         = real'(NUM_SAMPLES);

  sampler_state_e   r_state;
  logic [CNT_W-1:0] r_settle;
  logic [N_W-1:0]   r_n;
  real              r_v_sample;
  real              r_i_sample;
  real              r_v_sum;
  real              r_i_sum;
  real              r_v_min;
  real              r_v_max;

  logic [N_W-1:0]   w_n_next;

  assign w_n_next = r_n + N_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state              <= ST_IDLE;
      r_settle             <= '0;
      r_n                  <= '0;
      r_v_sample           <= 0.0;
      r_i_sample           <= 0.0;
      r_v_sum              <= 0.0;
      r_i_sum              <= 0.0;
      r_v_min              <= 0.0;
      r_v_max              <= 0.0;
      busy                 <= 1'b0;
      probe_voltage_toggle <= 1'b0;
      probe_current_toggle <= 1'b0;
      result_valid         <= 1'b0;
      v_mean               <= 0.0;
      v_min                <= 0.0;
      v_max                <= 0.0;
      i_mean               <= 0.0;
    end else begin
      if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          // A pending result blocks new requests; they are dropped, not queued.
          if (start && !result_valid) begin
            r_v_sum <= 0.0;
            r_i_sum <= 0.0;
            r_n     <= '0;
            busy    <= 1'b1;
            r_state <= ST_REQ_V;
          end
        end
        ST_REQ_V: begin
          probe_voltage_toggle <= ~probe_voltage_toggle;
          r_settle             <= c_settle_load;
          r_state              <= ST_WAIT_V;
        end
        ST_WAIT_V: begin
          if (r_settle == '0) begin
            r_v_sample <= voltage_in;
            r_state    <= ST_REQ_I;
          end else begin
            r_settle <= r_settle - CNT_W'(1);
          end
        end
        ST_REQ_I: begin
          probe_current_toggle <= ~probe_current_toggle;
          r_settle             <= c_settle_load;
          r_state              <= ST_WAIT_I;
        end
        ST_WAIT_I: begin
          if (r_settle == '0) begin
            r_i_sample <= current_in;
            r_state    <= ST_ACCUM;
          end else begin
            r_settle <= r_settle - CNT_W'(1);
          end
        end
        ST_ACCUM: begin
          r_v_sum <= r_v_sum + r_v_sample;
          r_i_sum <= r_i_sum + r_i_sample;
          r_n     <= w_n_next;
          if (r_n == '0) begin
            r_v_min <= r_v_sample;
            r_v_max <= r_v_sample;
          end else begin
            if (r_v_sample < r_v_min) r_v_min <= r_v_sample;
            if (r_v_sample > r_v_max) r_v_max <= r_v_sample;
          end
          r_state <= (w_n_next == c_num_samples) ? ST_DONE : ST_REQ_V;
        end
        ST_DONE: begin
          v_mean       <= r_v_sum / c_div;
          i_mean       <= r_i_sum / c_div;
          v_min        <= r_v_min;
          v_max        <= r_v_max;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_analog_probe_sampler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_analog_probe_sampler : directed + randomized bench with a probe model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_analog_probe_sampler;

  localparam int N_SMP  = 4;
  localparam int SETTLE = 2;
  localparam int LAT    = N_SMP * (2 * SETTLE + 3) + 1;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic probe_voltage_toggle;
  logic probe_current_toggle;
  real  voltage_in;
  real  current_in;
  logic result_valid;
  logic result_ready;
  real  v_mean, v_min, v_max, i_mean;

  int   tests_run    = 0;
  int   tests_failed = 0;

  real  v_vals[$];
  real  i_vals[$];
  int   v_idx, i_idx, v_flips, i_flips;

  analog_probe_sampler #(.NUM_SAMPLES(N_SMP), .SETTLE_CYCLES(SETTLE)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .busy                 (busy),
    .probe_voltage_toggle (probe_voltage_toggle),
    .probe_current_toggle (probe_current_toggle),
    .voltage_in           (voltage_in),
    .current_in           (current_in),
    .result_valid         (result_valid),
    .result_ready         (result_ready),
    .v_mean               (v_mean),
    .v_min                (v_min),
    .v_max                (v_max),
    .i_mean               (i_mean)
  );

  always #5 clk = ~clk;

  // Probe model: each toggle edge outside reset presents the next queued value.
  always @(probe_voltage_toggle) begin
    v_flips++;
    if (!rst && v_vals.size() > 0) begin
      voltage_in = v_vals[v_idx % v_vals.size()];
      v_idx++;
    end
  end

  always @(probe_current_toggle) begin
    i_flips++;
    if (!rst && i_vals.size() > 0) begin
      current_in = i_vals[i_idx % i_vals.size()];
      i_idx++;
    end
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_real(input string tag, input real obs, input real exp);
    bit ok;
    ok = ((obs - exp) < 1.0e-9) && ((exp - obs) < 1.0e-9);
    tests_run++;
    assert (ok === 1'b1) else begin
      tests_failed++;
      $error("FAIL %s: observed %g expected %g", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag);
    real vs, is, mn, mx, v;
    vs = 0.0; is = 0.0;
    mn = v_vals[0]; mx = v_vals[0];
    for (int j = 0; j < N_SMP; j++) begin
      v  = v_vals[j % v_vals.size()];
      vs = vs + v;
      is = is + i_vals[j % i_vals.size()];
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    check_real({tag, ".v_mean"}, v_mean, vs / N_SMP);
    check_real({tag, ".v_min"},  v_min,  mn);
    check_real({tag, ".v_max"},  v_max,  mx);
    check_real({tag, ".i_mean"}, i_mean, is / N_SMP);
  endtask

  // Pulses start and waits (bounded) for result_valid; checks latency.
  task automatic measure(input string tag);
    int lat;
    v_idx = 0; i_idx = 0; v_flips = 0; i_flips = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        lat = c;
        break;
      end
    end
    check_int({tag, ".latency"}, lat, LAT);
    check_bit({tag, ".busy_at_result"}, busy, 1'b0);
  endtask

  task automatic accept(input string tag);
    @(negedge clk); result_ready = 1'b1;
    @(posedge clk); #1;
    check_bit({tag, ".valid_cleared"}, result_valid, 1'b0);
    @(negedge clk); result_ready = 1'b0;
  endtask

  initial begin
    real held_mean, held_max;
    rst = 1'b1; start = 1'b0; result_ready = 1'b0;
    voltage_in = 0.0; current_in = 0.0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("reset.busy", busy, 1'b0);
    check_bit("reset.valid", result_valid, 1'b0);
    check_bit("reset.vtog", probe_voltage_toggle, 1'b0);
    check_bit("reset.itog", probe_current_toggle, 1'b0);
    check_real("reset.v_mean", v_mean, 0.0);
    check_real("reset.v_min", v_min, 0.0);
    check_real("reset.v_max", v_max, 0.0);
    check_real("reset.i_mean", i_mean, 0.0);
    rst = 1'b0;

    // Steady input
    v_vals = '{1.5}; i_vals = '{0.002};
    measure("steady");
    check_real("steady.v_mean", v_mean, 1.5);
    check_real("steady.v_min", v_min, 1.5);
    check_real("steady.v_max", v_max, 1.5);
    check_real("steady.i_mean", i_mean, 0.002);
    check_int("steady.vflips", v_flips, N_SMP);
    check_int("steady.iflips", i_flips, N_SMP);
    check_bit("steady.vtog_end", probe_voltage_toggle, 1'b0);
    check_bit("steady.itog_end", probe_current_toggle, 1'b0);
    accept("steady");

    // Ramp
    v_vals = '{0.1, 0.2, 0.3, 0.4}; i_vals = '{0.01, 0.02, 0.03, 0.04};
    measure("ramp");
    check_real("ramp.v_mean", v_mean, 0.25);
    check_real("ramp.v_min", v_min, 0.1);
    check_real("ramp.v_max", v_max, 0.4);
    check_real("ramp.i_mean", i_mean, 0.025);
    accept("ramp");
    check_real("ramp.retained", v_mean, 0.25);

    // Backpressure: start while a result is pending must be ignored
    v_vals = '{1.0, 3.0}; i_vals = '{0.5};
    measure("bp");
    held_mean = v_mean; held_max = v_max;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = (c == 4);
      if (c == 9) begin
        check_bit("bp.valid_held", result_valid, 1'b1);
        check_bit("bp.start_ignored", busy, 1'b0);
        check_real("bp.mean_stable", v_mean, held_mean);
        check_real("bp.max_stable", v_max, held_max);
      end
    end
    start = 1'b0;
    check_stats("bp");
    accept("bp");

    // Mid-run reset
    v_vals = '{1.5}; i_vals = '{0.002};
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_bit("midrst.busy", busy, 1'b0);
    check_bit("midrst.valid", result_valid, 1'b0);
    check_bit("midrst.vtog", probe_voltage_toggle, 1'b0);
    check_bit("midrst.itog", probe_current_toggle, 1'b0);
    check_real("midrst.v_mean", v_mean, 0.0);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_bit("midrst.no_result", result_valid, 1'b0);
    v_vals = '{0.8}; i_vals = '{0.001};
    measure("fresh");
    check_real("fresh.v_mean", v_mean, 0.8);
    accept("fresh");

    // Signed values
    v_vals = '{-0.5, 0.5}; i_vals = '{-0.1, 0.1};
    measure("signed");
    check_real("signed.v_mean", v_mean, 0.0);
    check_real("signed.v_min", v_min, -0.5);
    check_real("signed.v_max", v_max, 0.5);
    accept("signed");

    // Randomized measurements against the reference model
    for (int r = 0; r < 6; r++) begin
      v_vals = {}; i_vals = {};
      for (int j = 0; j < N_SMP; j++) begin
        v_vals.push_back(real'(int'($urandom_range(2000)) - 1000) / 1000.0);
        i_vals.push_back(real'(int'($urandom_range(200)) - 100) / 10000.0);
      end
      measure($sformatf("rand%0d", r));
      check_stats($sformatf("rand%0d", r));
      accept($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/analog_probe_sampler.md
# analog_probe_sampler

Clocked sequencer sitting directly downstream of the mixed-signal analog probe. On a start request it repeatedly triggers the probe's voltage and current toggles, waits a settle interval, and captures the returned `real` values. It then reduces `NUM_SAMPLES` captures into mean, minimum and maximum statistics, which it presents to the testbench or digital consumer through a valid/ready handshake.

## Interface
- `NUM_SAMPLES`, default 4: samples per measurement, legal range 1..256.
- `SETTLE_CYCLES`, default 2: clock cycles between a probe toggle and the capture of its value, minimum 1.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle measurement request.
- `busy`  out  1  high while a measurement is in progress.
- `probe_voltage_toggle`  out  1  inverted once per voltage sample; drives the probe's voltage trigger.
- `probe_current_toggle`  out  1  inverted once per current sample; drives the probe's current trigger.
- `voltage_in`  in  real  voltage returned by the probe.
- `current_in`  in  real  current returned by the probe.
- `result_valid`  out  1  statistics are available.
- `result_ready`  in  1  consumer accepts the statistics.
- `v_mean`, `v_min`, `v_max`  out  real  voltage statistics.
- `i_mean`  out  real  mean current.

## Operation
- States:
  - IDLE → REQ_V → WAIT_V → REQ_I → WAIT_I → ACCUM.
  - ACCUM → REQ_V when the sample count n < NUM_SAMPLES.
  - ACCUM → DONE when n == NUM_SAMPLES.
  - DONE → IDLE.
- IDLE:
  - `start` is accepted only when `result_valid` is 0.
  - On acceptance, clear the sums and n, then go to REQ_V.
  - `start` at any other time (busy, or result pending) is ignored; it is not queued.
- REQ_V: invert `probe_voltage_toggle` and load the settle counter with SETTLE_CYCLES-1.
- WAIT_V: decrement the counter. At 0, capture `voltage_in` into the sample register and go to REQ_I.
- REQ_I / WAIT_I: identical to REQ_V / WAIT_V, using `probe_current_toggle` and `current_in`.
- ACCUM:
  - Add both samples to the running sums and increment n.
  - For n == 0 before the increment, min and max load the sample directly. Otherwise compare strictly: less-than updates min, greater-than updates max.
- DONE:
  - Register `v_mean = v_sum / NUM_SAMPLES` and `i_mean = i_sum / NUM_SAMPLES`, and register min/max.
  - Set `result_valid`, then return to IDLE.
- Handshake:
  - `result_valid` stays high and all result outputs stay stable until a cycle with `result_valid && result_ready`; it clears on the following edge.
  - Result outputs retain their values after acceptance until the next DONE.
- `busy` is 1 in every state except IDLE.
- Arithmetic uses `real` throughout (simulation-only block). n is an 9-bit unsigned counter, so NUM_SAMPLES=256 does not wrap.

## Timing
- Reset values:
  - `busy` = 0, `result_valid` = 0.
  - Both toggles = 0.
  - All real outputs = 0.0; state = IDLE; n = 0.
- Per-sample latency is 2·SETTLE_CYCLES+3 cycles.
- If `start` is sampled at edge k, `result_valid` rises at edge k + NUM_SAMPLES·(2·SETTLE_CYCLES+3) + 1. With defaults this is k+29.
- The earliest new `start` is accepted on the cycle after the result handshake completes.
- Reset mid-operation:
  - Abort immediately; no `result_valid`; all outputs return to their reset values.
  - A toggle returning 1→0 produces one extra probe evaluation. This is harmless and its value is never captured.
- `start` and `rst` high in the same cycle: reset wins.
- `result_ready` is ignored while `result_valid` = 0.

## Structure
- Shared package `analog_probe_sampler_pkg`:
  - State enum `sampler_state_e`.
  - Constant `SAMPLER_MAX_SAMPLES = 256`.
  - Invalid-node sentinel `PROBE_INVALID_VALUE = 0.123456`, so consumers can flag captures equal to it.
- No sub-module: the settle counter and reduction logic stay inline in one module.

## Test plan
- Reset check: assert `rst` for 3 cycles → all outputs at reset values and both toggles 0.
- Steady-state measurement (defaults): `voltage_in` = 1.5, `current_in` = 0.002, pulse `start`.
  - `result_valid` rises exactly 29 cycles later.
  - `v_mean` = `v_min` = `v_max` = 1.5 and `i_mean` = 0.002.
  - Each toggle flips 4 times and ends at 0.
- Ramp: the bench drives `voltage_in` to 0.1, 0.2, 0.3, 0.4 on successive voltage-toggle edges → `v_mean` = 0.25, `v_min` = 0.1, `v_max` = 0.4.
- Backpressure: hold `result_ready` = 0 for 10 cycles and pulse `start` during that window.
  - `result_valid` stays high, outputs stay stable, and `start` is ignored.
  - Raising `result_ready` clears `result_valid` on the next edge.
- Mid-run reset: assert `rst` at cycle 10 after `start`.
  - `busy` drops and no result appears.
  - A fresh `start` with `voltage_in` = 0.8 yields `v_mean` = 0.8.
- Signed values: alternate `voltage_in` between -0.5 and 0.5 with NUM_SAMPLES = 4 → `v_mean` = 0.0, `v_min` = -0.5, `v_max` = 0.5.
